sa_operand_feeder: RTL and testbench

- Responder to the systolic-array controller's operand-load requests (rd_feature_ld / rd_weight_ld).
- Buffers host-written feature and weight vectors in two independent circular FIFOs.
- Returns one N_ROWS_ARRAY-wide vector per request, with 1-cycle latency.
- Generates the end_feature / end_weight indications that the controller and top level consume.

---
 rtl/sa_operand_feeder_if.sv | 46 ++++
 rtl/sa_operand_feeder.sv | 212 +++++++++++++++++++++
 tb/tb_sa_operand_feeder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sa_operand_feeder_if.sv
// Operand-feeder bus: host push side, controller load/return side and job status.
interface sa_operand_feeder_if #(
  parameter int N_ROWS_ARRAY = 4,
  parameter int I_WIDTH      = 8,
  parameter int F_WIDTH      = 8,
  parameter int TOTAL_WIDTH  = 16
);
  logic                           start_job_i;
  logic [TOTAL_WIDTH-1:0]         total_features_i;
  logic [TOTAL_WIDTH-1:0]         total_weights_i;
  logic                           wr_feature_i;
  logic [N_ROWS_ARRAY*I_WIDTH-1:0] wr_feature_data_i;
  logic                           wr_weight_i;
  logic [N_ROWS_ARRAY*F_WIDTH-1:0] wr_weight_data_i;
  logic                           feature_full_o;
  logic                           weight_full_o;
  logic                           rd_feature_ld_i;
  logic                           rd_weight_ld_i;
  logic [N_ROWS_ARRAY*I_WIDTH-1:0] in_feature_o;
  logic                           in_feature_valid_o;
  logic [N_ROWS_ARRAY*F_WIDTH-1:0] f_weight_o;
  logic                           f_weight_valid_o;
  logic                           end_feature_o;
  logic                           end_weight_o;
  logic                           busy_o;
  logic                           underflow_o;
  logic                           overflow_o;

  modport master (
    output start_job_i, total_features_i, total_weights_i,
    output wr_feature_i, wr_feature_data_i, wr_weight_i, wr_weight_data_i,
    output rd_feature_ld_i, rd_weight_ld_i,
    input  feature_full_o, weight_full_o,
    input  in_feature_o, in_feature_valid_o, f_weight_o, f_weight_valid_o,
    input  end_feature_o, end_weight_o, busy_o, underflow_o, overflow_o
  );

  modport slave (
    input  start_job_i, total_features_i, total_weights_i,
    input  wr_feature_i, wr_feature_data_i, wr_weight_i, wr_weight_data_i,
    input  rd_feature_ld_i, rd_weight_ld_i,
    output feature_full_o, weight_full_o,
    output in_feature_o, in_feature_valid_o, f_weight_o, f_weight_valid_o,
    output end_feature_o, end_weight_o, busy_o, underflow_o, overflow_o
  );
endinterface

// File: rtl/sa_operand_feeder.sv
// Feature/weight operand feeder for the systolic array: two circular FIFOs with 1-cycle load
// responses and per-job end indications. Define FEEDER_ERR_FLAGS_EN to build the sticky error flags.
module sa_operand_feeder #(
  parameter int N_ROWS_ARRAY = 4,
  parameter int I_WIDTH      = 8,
  parameter int F_WIDTH      = 8,
  parameter int DEPTH        = 16,
  parameter int PTR_WIDTH    = $clog2(DEPTH),
  parameter int TOTAL_WIDTH  = 16
) (
  input logic               clk_i,
  input logic               general_rst_i,
  sa_operand_feeder_if.slave bus
);
  localparam int FV_WIDTH  = N_ROWS_ARRAY * I_WIDTH;
  localparam int WV_WIDTH  = N_ROWS_ARRAY * F_WIDTH;
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]   CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0]   PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [TOTAL_WIDTH-1:0] TOT_ONE  = TOTAL_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   busy_q;
  logic   run;

  logic [FV_WIDTH-1:0]    feat_mem [DEPTH];
  logic [PTR_WIDTH-1:0]   feat_wr_ptr, feat_rd_ptr;
  logic [CNT_WIDTH-1:0]   feat_count;
  logic [TOTAL_WIDTH-1:0] feat_delivered, feat_total, feat_delivered_next;
  logic                   feat_end, feat_full, feat_empty, feat_pop, feat_push;
  logic [FV_WIDTH-1:0]    feat_data;
  logic                   feat_valid;

  logic [WV_WIDTH-1:0]    wgt_mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wgt_wr_ptr, wgt_rd_ptr;
  logic [CNT_WIDTH-1:0]   wgt_count;
  logic [TOTAL_WIDTH-1:0] wgt_delivered, wgt_total, wgt_delivered_next;
  logic                   wgt_end, wgt_full, wgt_empty, wgt_pop, wgt_push;
  logic [WV_WIDTH-1:0]    wgt_data;
  logic                   wgt_valid;

  // A start pulse takes the cycle for itself: loads issued alongside it are not served.
  always_comb begin
    run                 = (state_q == ST_RUN) && !bus.start_job_i;
    feat_full           = (feat_count == CNT_FULL);
    feat_empty          = (feat_count == '0);
    feat_pop            = run && bus.rd_feature_ld_i && !feat_empty && !feat_end;
    feat_push           = bus.wr_feature_i && (!feat_full || feat_pop);
    feat_delivered_next = feat_delivered + TOT_ONE;
    wgt_full            = (wgt_count == CNT_FULL);
    wgt_empty           = (wgt_count == '0);
    wgt_pop             = run && bus.rd_weight_ld_i && !wgt_empty && !wgt_end;
    wgt_push            = bus.wr_weight_i && (!wgt_full || wgt_pop);
    wgt_delivered_next  = wgt_delivered + TOT_ONE;
  end

  // Job phase next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_job_i) state_d = ST_RUN;
        else                 state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (bus.start_job_i)          state_d = ST_RUN;
        else if (feat_end && wgt_end) state_d = ST_DONE;
        else                          state_d = ST_RUN;
      end
      ST_DONE: begin
        if (bus.start_job_i) state_d = ST_RUN;
        else                 state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Job phase register and registered busy.
  always_ff @(posedge clk_i) begin
    if (!general_rst_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
    end
  end

  // Vector storage; contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (feat_push) feat_mem[feat_wr_ptr] <= bus.wr_feature_data_i;
    if (wgt_push)  wgt_mem[wgt_wr_ptr]   <= bus.wr_weight_data_i;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!general_rst_i) begin
      feat_wr_ptr <= '0;
      feat_rd_ptr <= '0;
      feat_count  <= '0;
      wgt_wr_ptr  <= '0;
      wgt_rd_ptr  <= '0;
      wgt_count   <= '0;
    end else begin
      if (feat_push) feat_wr_ptr <= feat_wr_ptr + PTR_ONE;
      if (feat_pop)  feat_rd_ptr <= feat_rd_ptr + PTR_ONE;
      if (wgt_push)  wgt_wr_ptr  <= wgt_wr_ptr + PTR_ONE;
      if (wgt_pop)   wgt_rd_ptr  <= wgt_rd_ptr + PTR_ONE;
      case ({feat_push, feat_pop})
        2'b10:   feat_count <= feat_count + CNT_ONE;
        2'b01:   feat_count <= feat_count - CNT_ONE;
        default: feat_count <= feat_count;
      endcase
      case ({wgt_push, wgt_pop})
        2'b10:   wgt_count <= wgt_count + CNT_ONE;
        2'b01:   wgt_count <= wgt_count - CNT_ONE;
        default: wgt_count <= wgt_count;
      endcase
    end
  end

  // Job counters; the end flag rises together with the valid of the last vector.
  always_ff @(posedge clk_i) begin
    if (!general_rst_i) begin
      feat_delivered <= '0;
      feat_total     <= '0;
      feat_end       <= 1'b0;
      wgt_delivered  <= '0;
      wgt_total      <= '0;
      wgt_end        <= 1'b0;
    end else if (bus.start_job_i) begin
      feat_delivered <= '0;
      feat_total     <= bus.total_features_i;
      feat_end       <= (bus.total_features_i == '0);
      wgt_delivered  <= '0;
      wgt_total      <= bus.total_weights_i;
      wgt_end        <= (bus.total_weights_i == '0);
    end else begin
      if (feat_pop) begin
        feat_delivered <= feat_delivered_next;
        feat_end       <= (feat_delivered_next == feat_total);
      end
      if (wgt_pop) begin
        wgt_delivered <= wgt_delivered_next;
        wgt_end       <= (wgt_delivered_next == wgt_total);
      end
    end
  end

  // Output registers: valid pulses for one cycle, data holds between pulses.
  always_ff @(posedge clk_i) begin
    if (!general_rst_i) begin
      feat_valid <= 1'b0;
      feat_data  <= '0;
      wgt_valid  <= 1'b0;
      wgt_data   <= '0;
    end else begin
      feat_valid <= feat_pop;
      wgt_valid  <= wgt_pop;
      if (feat_pop) feat_data <= feat_mem[feat_rd_ptr];
      if (wgt_pop)  wgt_data  <= wgt_mem[wgt_rd_ptr];
    end
  end

`ifdef FEEDER_ERR_FLAGS_EN
  logic underflow_q, overflow_q, underflow_ev, overflow_ev;

  always_comb begin
    underflow_ev = run && ((bus.rd_feature_ld_i && feat_empty && !feat_end) ||
                           (bus.rd_weight_ld_i  && wgt_empty  && !wgt_end));
    overflow_ev  = (bus.wr_feature_i && feat_full && !feat_pop) ||
                   (bus.wr_weight_i  && wgt_full  && !wgt_pop);
  end

  // Sticky error flags; a start pulse clears history but still records its own cycle.
  always_ff @(posedge clk_i) begin
    if (!general_rst_i) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (bus.start_job_i) begin
      underflow_q <= underflow_ev;
      overflow_q  <= overflow_ev;
    end else begin
      underflow_q <= underflow_q | underflow_ev;
      overflow_q  <= overflow_q | overflow_ev;
    end
  end

  assign bus.underflow_o = underflow_q;
  assign bus.overflow_o  = overflow_q;
`else
  assign bus.underflow_o = 1'b0;
  assign bus.overflow_o  = 1'b0;
`endif

  assign bus.feature_full_o     = feat_full;
  assign bus.weight_full_o      = wgt_full;
  assign bus.in_feature_o       = feat_data;
  assign bus.in_feature_valid_o = feat_valid;
  assign bus.f_weight_o         = wgt_data;
  assign bus.f_weight_valid_o   = wgt_valid;
  assign bus.end_feature_o      = feat_end;
  assign bus.end_weight_o       = wgt_end;
  assign bus.busy_o             = busy_q;
endmodule

// File: tb/tb_sa_operand_feeder.sv
// Scoreboard bench for sa_operand_feeder: queue-based reference model, random and directed traffic.
module tb_sa_operand_feeder;
  localparam int N = 4, IW = 8, FW = 8, DEPTH = 16, TW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_operand_feeder_if #(.N_ROWS_ARRAY(N), .I_WIDTH(IW), .F_WIDTH(FW), .TOTAL_WIDTH(TW)) bus ();

  sa_operand_feeder #(.N_ROWS_ARRAY(N), .I_WIDTH(IW), .F_WIDTH(FW), .DEPTH(DEPTH),
                      .TOTAL_WIDTH(TW)) dut (
    .clk_i(clk), .general_rst_i(rst_n), .bus(bus)
  );

  typedef struct {
    bit          fv, wv, fe, we, busy, ff, wf, un, ov;
    logic [31:0] fd, wd;
  } status_t;

  status_t     sq[$];
  logic [31:0] fexp[$], wexp[$];
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference model: job-level view of the feeder built on plain queues.
  logic [31:0] mf[$], mw[$];
  bit          running = 0, endf = 0, endw = 0, m_un = 0, m_ov = 0;
  int          delf = 0, delw = 0, totf = 0, totw = 0;
  logic [31:0] lastf = '0, lastw = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit start, input int tf, input int tw,
                       input bit wf, input logic [31:0] wfd, input bit ww, input logic [31:0] wwd,
                       input bit rf, input bit rw);
    status_t s;
    bit served, fpop, wpop, fun, wun, fov, wov;
    logic [31:0] v;
    rst_n                 = !rst;
    bus.start_job_i       = start;
    bus.total_features_i  = tf[15:0];
    bus.total_weights_i   = tw[15:0];
    bus.wr_feature_i      = wf;
    bus.wr_feature_data_i = wfd;
    bus.wr_weight_i       = ww;
    bus.wr_weight_data_i  = wwd;
    bus.rd_feature_ld_i   = rf;
    bus.rd_weight_ld_i    = rw;
    s.fv = 0;
    s.wv = 0;
    if (rst) begin
      mf.delete(); mw.delete();
      running = 0; endf = 0; endw = 0; m_un = 0; m_ov = 0;
      delf = 0; delw = 0; totf = 0; totw = 0; lastf = '0; lastw = '0;
    end else begin
      served = running && !start;
      fpop = served && rf && !endf && mf.size() > 0;
      wpop = served && rw && !endw && mw.size() > 0;
      fun  = served && rf && !endf && mf.size() == 0;
      wun  = served && rw && !endw && mw.size() == 0;
      fov  = wf && mf.size() == DEPTH && !fpop;
      wov  = ww && mw.size() == DEPTH && !wpop;
      if (fpop) begin v = mf.pop_front(); lastf = v; fexp.push_back(v); s.fv = 1; end
      if (wpop) begin v = mw.pop_front(); lastw = v; wexp.push_back(v); s.wv = 1; end
      if (wf && !fov) mf.push_back(wfd);
      if (ww && !wov) mw.push_back(wwd);
      // Job completes once both end flags were already standing before this edge.
      if (start) running = 1;
      else if (running && endf && endw) running = 0;
      if (start) begin
        delf = 0; totf = tf; endf = (tf == 0);
        delw = 0; totw = tw; endw = (tw == 0);
      end else begin
        if (fpop) begin delf++; endf = (delf == totf); end
        if (wpop) begin delw++; endw = (delw == totw); end
      end
`ifdef FEEDER_ERR_FLAGS_EN
      if (start) begin m_un = 0; m_ov = 0; end
      m_un = m_un | fun | wun;
      m_ov = m_ov | fov | wov;
`endif
    end
    s.fd = lastf; s.wd = lastw; s.fe = endf; s.we = endw; s.busy = running;
    s.ff = (mf.size() == DEPTH); s.wf = (mw.size() == DEPTH); s.un = m_un; s.ov = m_ov;
    sq.push_back(s);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, '0, 0, '0, 0, 0);
  endtask

  // Monitor: per-cycle status compare plus data scoreboard on each valid.
  status_t ms;
  always @(posedge clk) begin
    #1;
    if (sq.size() > 0) begin
      ms = sq.pop_front();
      chk("in_feature_valid", bus.in_feature_valid_o, ms.fv);
      chk("f_weight_valid", bus.f_weight_valid_o, ms.wv);
      chk("in_feature_hold", bus.in_feature_o, ms.fd);
      chk("f_weight_hold", bus.f_weight_o, ms.wd);
      chk("end_feature", bus.end_feature_o, ms.fe);
      chk("end_weight", bus.end_weight_o, ms.we);
      chk("busy", bus.busy_o, ms.busy);
      chk("feature_full", bus.feature_full_o, ms.ff);
      chk("weight_full", bus.weight_full_o, ms.wf);
      chk("underflow", bus.underflow_o, ms.un);
      chk("overflow", bus.overflow_o, ms.ov);
    end
    if (bus.in_feature_valid_o) begin
      if (fexp.size() == 0) chk("feature_unexpected_valid", 1, 0);
      else                  chk("feature_data", bus.in_feature_o, fexp.pop_front());
    end
    if (bus.f_weight_valid_o) begin
      if (wexp.size() == 0) chk("weight_unexpected_valid", 1, 0);
      else                  chk("weight_data", bus.f_weight_o, wexp.pop_front());
    end
  end

  initial begin
    cycle(1, 0, 0, 0, 0, '0, 0, '0, 0, 0);
    cycle(1, 0, 0, 0, 0, '0, 0, '0, 0, 0);
    // Two features, job of two, end flag with the second valid.
    cycle(0, 0, 0, 0, 1, 32'h04030201, 0, '0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h08070605, 0, '0, 0, 0);
    cycle(0, 1, 2, 0, 0, '0, 0, '0, 0, 0);
    cycle(0, 0, 0, 0, 0, '0, 0, '0, 1, 0);
    idle();
    cycle(0, 0, 0, 0, 0, '0, 0, '0, 1, 0);
    idle();
    idle();
    // Fill the weight FIFO, overflow, then write+read while full.
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 0, '0, 1, $urandom(), 0, 0);
    cycle(0, 0, 0, 0, 0, '0, 1, 32'hDEADBEEF, 0, 0);
    cycle(0, 1, 0, 5, 0, '0, 0, '0, 0, 0);
    cycle(0, 0, 0, 0, 0, '0, 1, 32'hCAFEF00D, 0, 1);
    idle();
    // Underflow on an empty feature FIFO.
    cycle(0, 1, 3, 5, 0, '0, 0, '0, 0, 0);
    cycle(0, 0, 0, 0, 0, '0, 0, '0, 1, 0);
    idle();
    // Zero-length job.
    cycle(0, 1, 0, 0, 0, '0, 0, '0, 0, 0);
    idle();
    idle();
    // Interleaved traffic through the weight FIFO across pointer wrap.
    cycle(0, 1, 0, 1000, 0, '0, 0, '0, 0, 0);
    for (int i = 0; i < 60; i++)
      cycle(0, 0, 0, 0, 0, '0, 1'($urandom_range(0, 1)), $urandom(), 0, 1'($urandom_range(0, 1)));
    // Fully random traffic with occasional restarts and resets.
    for (int i = 0; i < 500; i++)
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
            $urandom_range(0, 12), $urandom_range(0, 12),
            1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    // Reset mid-job with vectors queued, then a read underflows.
    cycle(1, 0, 0, 0, 0, '0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, $urandom(), 1, $urandom(), 0, 0);
    cycle(0, 1, 10, 10, 0, '0, 0, '0, 0, 0);
    cycle(0, 0, 0, 0, 0, '0, 0, '0, 1, 0);
    cycle(1, 0, 0, 0, 0, '0, 0, '0, 0, 0);
    idle();
    cycle(0, 1, 4, 4, 0, '0, 0, '0, 0, 0);
    cycle(0, 0, 0, 0, 0, '0, 0, '0, 1, 1);
    idle();
    idle();
    chk("status_drained", sq.size(), 0);
    chk("feature_sb_drained", fexp.size(), 0);
    chk("weight_sb_drained", wexp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
